// File: rtl/spi3_slave_regs_if.sv
// Pin-level bundle for the 3-wire SPI bus. sdio is split into in/out/oe so the
// tristate pad can live at the chip top.
interface spi3_slave_regs_if;
  logic sclk;
  logic cs;
  logic sdio_in;
  logic sdio_out;
  logic sdio_oe;

  modport master (output sclk, cs, sdio_in, input sdio_out, sdio_oe);
  modport slave  (input sclk, cs, sdio_in, output sdio_out, sdio_oe);
endinterface

// File: rtl/spi3_slave_regs.sv
// 3-wire SPI slave with a small register bank. It oversamples sclk/cs/sdio on
// the system clock and decodes frames of the form cmd, address, data.
module spi3_slave_regs #(
  parameter int a_width   = 16,
  parameter int d_width   = 8,
  parameter int idx_width = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi3_slave_regs_if.slave    spi,
  output logic                wr_stb,
  output logic [a_width-1:0]  wr_addr,
  output logic [d_width-1:0]  wr_data,
  output logic                rd_stb,
  output logic                busy,
  output logic                frame_err
);

  localparam int depth = 2 ** idx_width;
  localparam int cnt_w = $clog2((a_width > d_width ? a_width : d_width) + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic sdio_s1, sdio_s2;
  logic sclk_rise, sclk_fall, cs_fall;

  logic [cnt_w-1:0]   bit_cnt;
  logic               cmd_rd;
  logic [a_width-1:0] addr_sr;
  logic [d_width-1:0] data_sr;
  logic [d_width-1:0] out_sr;
  logic               oe_r;
  logic [d_width-1:0] bank [depth];

  logic [a_width-1:0] addr_next;
  logic [d_width-1:0] data_next;
  logic               last_addr, last_data;
  logic               do_write, do_read, abort_err;

  // Two flops per input for metastability; the third sclk/cs flop gives edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sdio_s1 <= 1'b0;
      sdio_s2 <= 1'b0;
    end else begin
      sclk_s1 <= spi.sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= spi.cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sdio_s1 <= spi.sdio_in;
      sdio_s2 <= sdio_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;

  assign addr_next = {addr_sr[a_width-2:0], sdio_s2};
  assign data_next = {data_sr[d_width-2:0], sdio_s2};
  assign last_addr = (bit_cnt == cnt_w'(a_width - 1));
  assign last_data = (bit_cnt == cnt_w'(d_width - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Chip select going high wins over any bit arriving in the same clock.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_read   = 1'b0;
    abort_err = 1'b0;
    if (cs_s2 && (state != IDLE)) begin
      state_nxt = IDLE;
      abort_err = (state inside {ADDR, WDATA, RDATA});
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) state_nxt = CMD;
        end
        CMD: begin
          if (sclk_rise) state_nxt = ADDR;
        end
        ADDR: begin
          if (sclk_rise && last_addr) begin
            state_nxt = cmd_rd ? RDATA : WDATA;
            do_read   = cmd_rd;
          end
        end
        WDATA: begin
          if (sclk_rise && last_data) begin
            state_nxt = WAIT;
            do_write  = 1'b1;
          end
        end
        RDATA: begin
          if (sclk_rise && last_data) state_nxt = WAIT;
        end
        WAIT: begin
          state_nxt = WAIT;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // The first fall of the read phase precedes the first sample, so the MSB is
  // held until at least one rise has been counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      cmd_rd    <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      out_sr    <= '0;
      oe_r      <= 1'b0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= do_write;
      rd_stb    <= do_read;
      frame_err <= abort_err;
      busy      <= ~cs_s2;
      oe_r      <= (state_nxt == RDATA);

      if (state_nxt != state) begin
        bit_cnt <= '0;
      end else if (sclk_rise && (state inside {ADDR, WDATA, RDATA})) begin
        bit_cnt <= bit_cnt + cnt_w'(1);
      end

      case (state)
        CMD: begin
          if (sclk_rise) cmd_rd <= sdio_s2;
        end
        ADDR: begin
          if (sclk_rise) addr_sr <= addr_next;
        end
        WDATA: begin
          if (sclk_rise) data_sr <= data_next;
        end
        RDATA: begin
          if (sclk_fall && (bit_cnt != '0)) out_sr <= {out_sr[d_width-2:0], 1'b0};
        end
        default: begin
        end
      endcase

      if (do_write) begin
        wr_addr <= addr_sr;
        wr_data <= data_next;
      end
      if (do_read) begin
        out_sr <= bank[addr_next[idx_width-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) bank[i] <= '0;
    end else if (do_write) begin
      bank[addr_sr[idx_width-1:0]] <= data_next;
    end
  end

  assign spi.sdio_oe  = oe_r;
  assign spi.sdio_out = oe_r & out_sr[d_width-1];

endmodule

// File: tb/tb_spi3_slave_regs.sv
// Randomized bench for spi3_slave_regs: a bit-banging SPI master drives frames
// and a flat register-array model predicts strobes and read data.
module tb_spi3_slave_regs;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int FBITS = 1 + AW + DW;
  localparam int HALF  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_stb;
  logic          busy;
  logic          frame_err;

  spi3_slave_regs_if bus();

  spi3_slave_regs #(.a_width(AW), .d_width(DW), .idx_width(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (bus.slave),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_stb    (rd_stb),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int wr_cnt    = 0;
  int rd_cnt    = 0;
  int err_cnt   = 0;

  logic [DW-1:0] model_bank [16];

  // Strobe cycles are counted so a stuck strobe shows up as more than one.
  always @(negedge clk) begin
    if (wr_stb)    wr_cnt  <= wr_cnt + 1;
    if (rd_stb)    rd_cnt  <= rd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sclkBit(input logic b, output logic rb, output logic oe);
    bus.sdio_in = b;
    repeat (HALF) @(negedge clk);
    rb = bus.sdio_out;
    oe = bus.sdio_oe;
    bus.sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input int nbits, output logic [DW-1:0] rdata, output int oe_bits);
    logic [FBITS-1:0] fb;
    logic rb, oe;
    fb      = {cmd, addr, data};
    rdata   = '0;
    oe_bits = 0;
    bus.cs  = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclkBit(fb[FBITS-1-i], rb, oe);
      if (i > AW) rdata = {rdata[DW-2:0], rb};
      if (oe) oe_bits++;
    end
    if (nbits > 3) checkOutput("busy_mid", {31'd0, busy}, 32'd1);
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic runTxn(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int nbits);
    int w0, r0, e0, oe_bits, exp_oe;
    logic [DW-1:0] rdata;
    logic full;
    w0 = wr_cnt;
    r0 = rd_cnt;
    e0 = err_cnt;
    applyStimulus(cmd, addr, data, nbits, rdata, oe_bits);
    full   = (nbits == FBITS);
    exp_oe = (cmd && nbits > AW + 1) ? nbits - (AW + 1) : 0;
    checkOutput("wr_stb_count", wr_cnt - w0, (!cmd && full) ? 1 : 0);
    checkOutput("rd_stb_count", rd_cnt - r0, (cmd && nbits >= AW + 1) ? 1 : 0);
    checkOutput("frame_err_count", err_cnt - e0, (nbits >= 1 && !full) ? 1 : 0);
    checkOutput("oe_bits", oe_bits, exp_oe);
    checkOutput("oe_after", {31'd0, bus.sdio_oe}, 32'd0);
    checkOutput("busy_after", {31'd0, busy}, 32'd0);
    if (cmd && full) checkOutput("read_data", {24'd0, rdata}, {24'd0, model_bank[addr[3:0]]});
    if (!cmd && full) begin
      model_bank[addr[3:0]] = data;
      checkOutput("wr_addr", {16'd0, wr_addr}, {16'd0, addr});
      checkOutput("wr_data", {24'd0, wr_data}, {24'd0, data});
    end
  endtask

  initial begin
    logic rb, oe;
    logic [FBITS-1:0] fb;
    int w0, r0, e0;

    for (int i = 0; i < 16; i++) model_bank[i] = '0;
    rst         = 1'b1;
    bus.sclk    = 1'b0;
    bus.cs      = 1'b1;
    bus.sdio_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_outputs", {wr_stb, rd_stb, busy, frame_err, bus.sdio_oe, bus.sdio_out}, 32'd0);
    checkOutput("reset_wr_addr", {16'd0, wr_addr}, 32'd0);
    checkOutput("reset_wr_data", {24'd0, wr_data}, 32'd0);
    rst = 1'b0;

    $display("[TB] idle sclk toggling with cs high");
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.sclk = ~bus.sclk;
      bus.sdio_in = 1'(i);
      repeat (HALF) @(negedge clk);
    end
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idle_strobes", (wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0), 32'd0);
    checkOutput("idle_outputs", {busy, bus.sdio_oe, bus.sdio_out}, 32'd0);

    $display("[TB] directed write/read sequences");
    runTxn(1'b0, 16'hfffe, 8'hfe, FBITS);
    runTxn(1'b1, 16'hfffe, 8'h00, FBITS);
    runTxn(1'b0, 16'hfffd, 8'hfd, FBITS);
    runTxn(1'b1, 16'hfffd, 8'h00, FBITS);
    runTxn(1'b0, 16'hfffc, 8'hfc, FBITS);
    runTxn(1'b1, 16'hfffc, 8'h00, FBITS);
    runTxn(1'b1, 16'h000c, 8'h00, FBITS);
    checkOutput("alias_model", {24'd0, model_bank[12]}, 32'h0000_00fc);

    $display("[TB] aborted write");
    runTxn(1'b0, 16'h0003, 8'hff, 1 + AW + 5);
    runTxn(1'b1, 16'h0003, 8'h00, FBITS);

    $display("[TB] reset during read data phase");
    fb = {1'b1, 16'hfffe, 8'h00};
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < AW + 3; i++) sclkBit(fb[FBITS-1-i], rb, oe);
    checkOutput("oe_before_rst", {31'd0, bus.sdio_oe}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("oe_async_rst", {31'd0, bus.sdio_oe}, 32'd0);
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) model_bank[i] = '0;
    runTxn(1'b1, 16'hfffe, 8'h00, FBITS);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      logic cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int nbits;
      cmd   = 1'($urandom_range(0, 1));
      addr  = AW'($urandom);
      data  = DW'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FBITS - 1)) : FBITS;
      runTxn(cmd, addr, data, nbits);
    end
    for (int i = 0; i < 16; i++) runTxn(1'b1, AW'(i), 8'h00, FBITS);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
